// File: rtl/fb_span_writer_if.sv
// Command and SRAM bus bundle for the framebuffer span writer.
// The master view belongs to the span writer (it takes commands and drives
// the SRAM access); the slave view belongs to the CPU/SRAM side.
interface fb_span_writer_if;
    // command port
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0;
    logic [9:0]  cmd_x1;
    logic [8:0]  cmd_y;
    logic        cmd_color;
    // SRAM port
    logic [31:0] SRAM_data_in;
    logic        SRAM_busy;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;
    logic [31:0] SRAM_data_out;
    logic        read_en;
    logic        write_en;
    // status
    logic        busy;
    logic        cmd_err;

    modport master (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y, cmd_color,
        input  SRAM_data_in, SRAM_busy,
        output cmd_ready, word_address_dest, byte_select, SRAM_data_out,
        output read_en, write_en, busy, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y, cmd_color,
        output SRAM_data_in, SRAM_busy,
        input  cmd_ready, word_address_dest, byte_select, SRAM_data_out,
        input  read_en, write_en, busy, cmd_err
    );
endinterface

// File: rtl/fb_span_writer.sv
// Framebuffer span writer: turns a horizontal span-fill command into a
// sequence of SRAM word accesses. Words only partly covered by the span are
// read, merged with the pixel mask and written back; fully covered words are
// written directly. All SRAM outputs are decoded from registered state, so an
// asynchronous reset drops any request immediately.
module fb_span_writer #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          H_PIXELS  = 640,
    parameter int          V_LINES   = 480
) (
    input  logic            clk,
    input  logic            nrst,
    fb_span_writer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [10:0] H_LIMIT = 11'(H_PIXELS);
    localparam logic [9:0]  V_LIMIT = 10'(V_LINES);

    state_t      state_q,    state_d;
    logic [9:0]  x0_q,       x0_d;
    logic [9:0]  x1_q,       x1_d;
    logic [31:0] lineBase_q, lineBase_d;
    logic        color_q,    color_d;
    logic [4:0]  wordIdx_q,  wordIdx_d;
    logic [31:0] readData_q, readData_d;
    logic        err_q,      err_d;

    logic        cmdBad;
    logic        firstFull;
    logic        lastWord;
    logic        nextFull;
    logic [4:0]  loBit;
    logic [4:0]  hiBit;
    logic [31:0] pixMask;
    logic [31:0] curAddr;
    logic [3:0]  maskLanes;
    logic [31:0] mergedData;

    logic        readEn;
    logic        writeEn;
    logic [31:0] addrOut;
    logic [3:0]  laneOut;
    logic [31:0] dataOut;

    // Decode the current word: inclusive pixel mask, byte lanes, merged data,
    // and the shape of the next word and of a newly offered command.
    always_comb begin
        cmdBad     = ({1'b0, bus.cmd_x1} >= H_LIMIT) || ({1'b0, bus.cmd_y} >= V_LIMIT) ||
                     (bus.cmd_x1 < bus.cmd_x0);
        firstFull  = (bus.cmd_x0[4:0] == 5'd0) &&
                     ((bus.cmd_x0[9:5] != bus.cmd_x1[9:5]) || (bus.cmd_x1[4:0] == 5'd31));
        lastWord   = (wordIdx_q == x1_q[9:5]);
        nextFull   = ((wordIdx_q + 5'd1) != x1_q[9:5]) || (x1_q[4:0] == 5'd31);
        loBit      = (wordIdx_q == x0_q[9:5]) ? x0_q[4:0] : 5'd0;
        hiBit      = lastWord ? x1_q[4:0] : 5'd31;
        pixMask    = (32'hFFFF_FFFF << loBit) & (32'hFFFF_FFFF >> (5'd31 - hiBit));
        curAddr    = lineBase_q + {27'd0, wordIdx_q};
        maskLanes  = {|pixMask[31:24], |pixMask[23:16], |pixMask[15:8], |pixMask[7:0]};
        mergedData = color_q ? (readData_q | pixMask) : (readData_q & ~pixMask);
    end

    // Next-state and SRAM request decode; requests are held while the SRAM is busy.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        lineBase_d = lineBase_q;
        color_d    = color_q;
        wordIdx_d  = wordIdx_q;
        readData_d = readData_q;
        err_d      = 1'b0;
        readEn     = 1'b0;
        writeEn    = 1'b0;
        addrOut    = 32'd0;
        laneOut    = 4'd0;
        dataOut    = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmdBad) begin
                        err_d = 1'b1;
                    end else begin
                        x0_d       = bus.cmd_x0;
                        x1_d       = bus.cmd_x1;
                        color_d    = bus.cmd_color;
                        lineBase_d = BASE_ADDR + {19'd0, bus.cmd_y, 4'd0} + {21'd0, bus.cmd_y, 2'd0};
                        wordIdx_d  = bus.cmd_x0[9:5];
                        state_d    = firstFull ? WRITE : READ;
                    end
                end
            end
            READ: begin
                readEn  = 1'b1;
                addrOut = curAddr;
                laneOut = 4'hF;
                if (!bus.SRAM_busy) begin
                    readData_d = bus.SRAM_data_in;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                writeEn = 1'b1;
                addrOut = curAddr;
                laneOut = maskLanes;
                dataOut = mergedData;
                if (!bus.SRAM_busy) begin
                    if (lastWord) begin
                        state_d = IDLE;
                    end else begin
                        wordIdx_d  = wordIdx_q + 5'd1;
                        readData_d = 32'd0;
                        state_d    = nextFull ? WRITE : READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; asynchronous reset discards any command in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            x0_q       <= 10'd0;
            x1_q       <= 10'd0;
            lineBase_q <= 32'd0;
            color_q    <= 1'b0;
            wordIdx_q  <= 5'd0;
            readData_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            lineBase_q <= lineBase_d;
            color_q    <= color_d;
            wordIdx_q  <= wordIdx_d;
            readData_q <= readData_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready         = (state_q == IDLE);
    assign bus.busy              = (state_q != IDLE);
    assign bus.cmd_err           = err_q;
    assign bus.read_en           = readEn;
    assign bus.write_en          = writeEn;
    assign bus.word_address_dest = addrOut;
    assign bus.byte_select       = laneOut;
    assign bus.SRAM_data_out     = dataOut;

endmodule

// File: tb/tb_fb_span_writer.sv
// Testbench for fb_span_writer: a table of span commands with hand-computed
// SRAM traffic, plus hand-written busy-stall and mid-command reset sequences.
module tb_fb_span_writer;

    logic clk;
    logic nrst;

    fb_span_writer_if bus();

    fb_span_writer #(
        .BASE_ADDR(32'd0),
        .H_PIXELS (640),
        .V_LINES  (480)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: words never written in the current epoch read as fillWord
    logic [31:0] mem [16384];
    int          wep [16384];
    int          epoch;
    logic [31:0] fillWord;
    logic [31:0] memRdData;
    logic [31:0] wrMerged;
    int          readCount;
    int          writeCount;
    int          overlapCount;
    logic [31:0] logAddr [512];
    logic [31:0] logData [512];
    logic [3:0]  logLane [512];

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [9:0]  x0;
        logic [9:0]  x1;
        logic [8:0]  y;
        logic        color;
        logic [31:0] fill;
        logic        expErr;
        int          expEdges;
        int          expReads;
        int          expWrites;
        logic [31:0] fAddr;
        logic [31:0] fData;
        logic [3:0]  fLane;
        logic [31:0] lAddr;
        logic [31:0] lData;
        logic [3:0]  lLane;
    } vec_t;

    vec_t vecs [10];
    vec_t postReset;

    always_comb begin
        memRdData = (wep[bus.word_address_dest[13:0]] == epoch) ?
                    mem[bus.word_address_dest[13:0]] : fillWord;
        wrMerged = memRdData;
        for (int b = 0; b < 4; b++)
            if (bus.byte_select[b]) wrMerged[8*b +: 8] = bus.SRAM_data_out[8*b +: 8];
    end

    assign bus.SRAM_data_in = memRdData;

    always @(posedge clk) begin
        if (bus.read_en && bus.write_en) overlapCount <= overlapCount + 1;
        if (bus.read_en && !bus.SRAM_busy) readCount <= readCount + 1;
        if (bus.write_en && !bus.SRAM_busy) begin
            mem[bus.word_address_dest[13:0]] <= wrMerged;
            wep[bus.word_address_dest[13:0]] <= epoch;
            logAddr[writeCount[8:0]]         <= bus.word_address_dest;
            logData[writeCount[8:0]]         <= bus.SRAM_data_out;
            logLane[writeCount[8:0]]         <= bus.byte_select;
            writeCount                       <= writeCount + 1;
        end
    end

    initial begin
        readCount    = 0;
        writeCount   = 0;
        overlapCount = 0;
        for (int i = 0; i < 16384; i++) wep[i] = -1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // drive a command for one accept edge, then drop cmd_valid and scramble inputs
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = v.x0;
        bus.cmd_x1    = v.x1;
        bus.cmd_y     = v.y;
        bus.cmd_color = v.color;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = 10'h3FF;
        bus.cmd_x1    = 10'h000;
        bus.cmd_y     = 9'h1FF;
        bus.cmd_color = ~v.color;
    endtask

    // count edges from the accept edge until cmd_ready is seen high again
    task automatic waitIdle(input int startEdges, output int edges, output logic errSeen);
        edges = startEdges;
        @(negedge clk);
        errSeen = bus.cmd_err;
        while (!bus.cmd_ready && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic runVector(input vec_t v);
        int   rd0, wr0, edges, nWr;
        logic errSeen;
        epoch++;
        fillWord = v.fill;
        rd0 = readCount;
        wr0 = writeCount;
        applyStimulus(v);
        waitIdle(1, edges, errSeen);
        checkOutput({v.name, " cmd_err"}, {31'd0, errSeen}, {31'd0, v.expErr});
        checkOutput({v.name, " edges"}, edges, v.expEdges);
        @(posedge clk);
        @(negedge clk);
        checkOutput({v.name, " cmd_err_drop"}, {31'd0, bus.cmd_err}, 32'd0);
        nWr = writeCount - wr0;
        checkOutput({v.name, " reads"}, readCount - rd0, v.expReads);
        checkOutput({v.name, " writes"}, nWr, v.expWrites);
        if (nWr > 0 && v.expWrites > 0) begin
            checkOutput({v.name, " first_addr"}, logAddr[wr0], v.fAddr);
            checkOutput({v.name, " first_data"}, logData[wr0], v.fData);
            checkOutput({v.name, " first_lane"}, {28'd0, logLane[wr0]}, {28'd0, v.fLane});
            checkOutput({v.name, " last_addr"}, logAddr[wr0 + nWr - 1], v.lAddr);
            checkOutput({v.name, " last_data"}, logData[wr0 + nWr - 1], v.lData);
            checkOutput({v.name, " last_lane"}, {28'd0, logLane[wr0 + nWr - 1]}, {28'd0, v.lLane});
        end
    endtask

    initial begin
        int          edges, wr0, rd0;
        logic        errSeen;
        logic [31:0] holdAddr;
        vec_t        v;

        checks   = 0;
        failures = 0;
        epoch    = 0;
        fillWord = 32'd0;

        //          name        x0   x1   y    c     fill           err  edg rd wr fAddr   fData          fLn     lAddr   lData          lLn
        vecs[0] = '{"pixel5",   5,   5,   0,   1'b1, 32'h0000_0000, 1'b0, 3, 1, 1, 32'd0,  32'h0000_0020, 4'b0001, 32'd0,  32'h0000_0020, 4'b0001};
        vecs[1] = '{"fullclr",  0,   639, 2,   1'b0, 32'hFFFF_FFFF, 1'b0, 21, 0, 20, 32'd40, 32'h0000_0000, 4'hF,   32'd59, 32'h0000_0000, 4'hF};
        vecs[2] = '{"cross",    30,  33,  1,   1'b0, 32'hFFFF_FFFF, 1'b0, 5, 2, 2, 32'd20, 32'h3FFF_FFFF, 4'b1000, 32'd21, 32'hFFFF_FFFC, 4'b0001};
        vecs[3] = '{"err_y480", 0,   10,  480, 1'b1, 32'h0000_0000, 1'b1, 1, 0, 0, 32'd0,  32'd0,         4'd0,   32'd0,  32'd0,         4'd0};
        vecs[4] = '{"err_x1lt", 10,  9,   3,   1'b1, 32'h0000_0000, 1'b1, 1, 0, 0, 32'd0,  32'd0,         4'd0,   32'd0,  32'd0,         4'd0};
        vecs[5] = '{"err_x640", 600, 640, 3,   1'b1, 32'h0000_0000, 1'b1, 1, 0, 0, 32'd0,  32'd0,         4'd0,   32'd0,  32'd0,         4'd0};
        vecs[6] = '{"fullword", 0,   31,  479, 1'b1, 32'h0000_0000, 1'b0, 2, 0, 1, 32'd9580, 32'hFFFF_FFFF, 4'hF, 32'd9580, 32'hFFFF_FFFF, 4'hF};
        vecs[7] = '{"mid",      8,   23,  3,   1'b1, 32'h0000_0000, 1'b0, 3, 1, 1, 32'd60, 32'h00FF_FF00, 4'b0110, 32'd60, 32'h00FF_FF00, 4'b0110};
        vecs[8] = '{"three",    16,  80,  4,   1'b1, 32'h0000_0000, 1'b0, 6, 2, 3, 32'd80, 32'hFFFF_0000, 4'b1100, 32'd82, 32'h0001_FFFF, 4'b0111};
        vecs[9] = '{"lastpix",  639, 639, 5,   1'b0, 32'hFFFF_FFFF, 1'b0, 3, 1, 1, 32'd119, 32'h7FFF_FFFF, 4'b1000, 32'd119, 32'h7FFF_FFFF, 4'b1000};
        postReset = '{"postrst", 40, 40,  7,   1'b1, 32'h0000_0000, 1'b0, 3, 1, 1, 32'd141, 32'h0000_0100, 4'b0010, 32'd141, 32'h0000_0100, 4'b0010};

        nrst          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = 10'd0;
        bus.cmd_x1    = 10'd0;
        bus.cmd_y     = 9'd0;
        bus.cmd_color = 1'b0;
        bus.SRAM_busy = 1'b0;

        // reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        checkOutput("rst busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst read_en", {31'd0, bus.read_en}, 32'd0);
        checkOutput("rst write_en", {31'd0, bus.write_en}, 32'd0);
        checkOutput("rst cmd_err", {31'd0, bus.cmd_err}, 32'd0);
        checkOutput("rst addr", bus.word_address_dest, 32'd0);
        checkOutput("rst lane", {28'd0, bus.byte_select}, 32'd0);
        checkOutput("rst data", bus.SRAM_data_out, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst idle", {30'd0, bus.read_en, bus.write_en}, 32'd0);
        checkOutput("post_rst ready", {31'd0, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) runVector(vecs[i]);

        // busy stall of three cycles during the read of a single pixel
        v = '{"stall", 7, 7, 6, 1'b1, 32'h0000_0000, 1'b0, 6, 1, 1, 32'd120, 32'h0000_0080, 4'b0001, 32'd120, 32'h0000_0080, 4'b0001};
        epoch++;
        fillWord = v.fill;
        rd0 = readCount;
        wr0 = writeCount;
        applyStimulus(v);
        bus.SRAM_busy = 1'b1;
        holdAddr = 32'd120;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall read_en", {31'd0, bus.read_en}, 32'd1);
            checkOutput("stall addr", bus.word_address_dest, holdAddr);
            checkOutput("stall lane", {28'd0, bus.byte_select}, 32'hF);
            @(posedge clk);
            #1;
        end
        bus.SRAM_busy = 1'b0;
        waitIdle(4, edges, errSeen);
        checkOutput("stall edges", edges, v.expEdges);
        checkOutput("stall reads", readCount - rd0, 1);
        checkOutput("stall writes", writeCount - wr0, 1);
        checkOutput("stall data", logData[wr0], v.fData);
        checkOutput("stall lane_w", {28'd0, logLane[wr0]}, {28'd0, v.fLane});

        // full-line fill interrupted by reset after five writes
        v = '{"rstmid", 0, 639, 7, 1'b1, 32'h0000_0000, 1'b0, 21, 0, 20, 32'd140, 32'hFFFF_FFFF, 4'hF, 32'd159, 32'hFFFF_FFFF, 4'hF};
        epoch++;
        fillWord = v.fill;
        wr0 = writeCount;
        applyStimulus(v);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rstmid writes_before", writeCount - wr0, 5);
        nrst = 1'b0;
        #1;
        checkOutput("rstmid write_en", {31'd0, bus.write_en}, 32'd0);
        checkOutput("rstmid read_en", {31'd0, bus.read_en}, 32'd0);
        checkOutput("rstmid addr", bus.word_address_dest, 32'd0);
        checkOutput("rstmid data", bus.SRAM_data_out, 32'd0);
        checkOutput("rstmid lane", {28'd0, bus.byte_select}, 32'd0);
        checkOutput("rstmid ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid writes_after", writeCount - wr0, 5);
        runVector(postReset);

        checkOutput("rw_overlap", overlapCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
